// File: rtl/light_pkg.sv
// Shared types and constants for the traffic-light phase decoder.
package light_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DWELL,
        ST_SYNC,
        ST_ERR
    } state_t;

    typedef enum logic {
        CLS_RUN   = 1'b0,
        CLS_FLASH = 1'b1
    } class_t;

    // Lamp encodings are {red, yellow, green}.
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    localparam int unsigned NUM_PHASES = 10;

    function automatic class_t class_of(input logic day_night, input logic [2:0] mode);
        return (day_night && (mode <= 3'd1)) ? CLS_RUN : CLS_FLASH;
    endfunction

endpackage

// File: rtl/phase_rom.sv
// Combinational phase table: {class, phase, mode} -> lamps, walk and dwell.
module phase_rom
    import light_pkg::*;
#(
    parameter int unsigned GREEN_T = 20,
    parameter int unsigned SHORT_T = 10,
    parameter int unsigned YEL_T   = 4,
    parameter int unsigned CLR_T   = 2,
    parameter int unsigned FLASH_T = 8
) (
    input  class_t     cls,
    input  logic [3:0] phase,
    input  logic [2:0] mode,
    output logic [2:0] main_lamp,
    output logic [2:0] side_lamp,
    output logic       walk,
    output logic [7:0] dwell
);

    always_comb begin
        main_lamp = RED;
        side_lamp = RED;
        walk      = 1'b0;
        dwell     = CLR_T[7:0];
        if (cls == CLS_RUN) begin
            case (phase)
                4'd2: begin main_lamp = GRN; dwell = GREEN_T[7:0]; end
                4'd3: begin main_lamp = YEL; dwell = YEL_T[7:0];   end
                4'd5: begin
                    side_lamp = GRN;
                    dwell     = GREEN_T[7:0];
                    walk      = (mode == 3'd1);
                end
                4'd6: begin side_lamp = YEL; dwell = YEL_T[7:0];   end
                4'd8: begin main_lamp = GRN; dwell = SHORT_T[7:0]; end
                4'd9: begin main_lamp = YEL; dwell = YEL_T[7:0];   end
                default: ;
            endcase
        end else begin
            // Flashing: only phase 0 lights anything, every phase uses the flash half-period.
            dwell     = FLASH_T[7:0];
            main_lamp = (phase == 4'd0) ? YEL : OFF;
            side_lamp = (phase == 4'd0) ? RED : OFF;
        end
    end

endmodule

// File: rtl/light_decoder.sv
// Phase sequencer: loads a phase from idx, dwells, pulses step to advance the index generator.
module light_decoder
    import light_pkg::*;
#(
    parameter int unsigned GREEN_T = 20,
    parameter int unsigned SHORT_T = 10,
    parameter int unsigned YEL_T   = 4,
    parameter int unsigned CLR_T   = 2,
    parameter int unsigned FLASH_T = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       day_night,
    input  logic [2:0] mode,
    input  logic [6:0] idx,
    output logic       step,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk,
    output logic       err
);

    localparam logic [3:0] MAX_PHASE = 4'(NUM_PHASES - 1);

    state_t     state_q, state_d;
    class_t     cls_q, cls_d;
    logic [7:0] cnt_q, cnt_d;
    logic       step_q, step_d;
    logic [2:0] main_q, main_d;
    logic [2:0] side_q, side_d;
    logic       walk_q, walk_d;
    logic       err_q, err_d;

    logic [3:0] phase;
    logic       illegal;
    class_t     cur_cls;
    logic [2:0] rom_main, rom_side;
    logic       rom_walk;
    logic [7:0] rom_dwell;

    assign phase   = idx[6:3];
    assign illegal = (idx[2:0] != 3'd0) || (phase > MAX_PHASE);
    assign cur_cls = class_of(day_night, mode);

    phase_rom #(
        .GREEN_T(GREEN_T),
        .SHORT_T(SHORT_T),
        .YEL_T  (YEL_T),
        .CLR_T  (CLR_T),
        .FLASH_T(FLASH_T)
    ) u_rom (
        .cls      (cur_cls),
        .phase    (phase),
        .mode     (mode),
        .main_lamp(rom_main),
        .side_lamp(rom_side),
        .walk     (rom_walk),
        .dwell    (rom_dwell)
    );

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        cnt_d   = cnt_q;
        step_d  = 1'b0;
        main_d  = main_q;
        side_d  = side_q;
        walk_d  = walk_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: state_d = ST_LOAD;
            ST_LOAD: begin
                if (illegal) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                    main_d  = RED;
                    side_d  = RED;
                    walk_d  = 1'b0;
                end else begin
                    state_d = ST_DWELL;
                    main_d  = rom_main;
                    side_d  = rom_side;
                    walk_d  = rom_walk;
                    cnt_d   = rom_dwell - 8'd1;
                    cls_d   = cur_cls;
                end
            end
            ST_DWELL: begin
                // A class change ends the phase early so the new class is picked up at the next LOAD.
                if ((cur_cls != cls_q) || (cnt_q == 8'd0)) begin
                    step_d  = 1'b1;
                    state_d = ST_SYNC;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_SYNC: state_d = ST_LOAD;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cls_q   <= CLS_RUN;
            cnt_q   <= 8'd0;
            step_q  <= 1'b0;
            main_q  <= RED;
            side_q  <= RED;
            walk_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            main_q  <= main_d;
            side_q  <= side_d;
            walk_q  <= walk_d;
            err_q   <= err_d;
        end
    end

    assign step       = step_q;
    assign main_light = main_q;
    assign side_light = side_q;
    assign walk       = walk_q;
    assign err        = err_q;

endmodule

// File: tb/tb_light_decoder.sv
// Bench for light_decoder: vector table, directed corner sequences and randomized phase runs.
module tb_light_decoder;

    localparam int GREEN_T = 20;
    localparam int SHORT_T = 10;
    localparam int YEL_T   = 4;
    localparam int CLR_T   = 2;
    localparam int FLASH_T = 8;

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;
    localparam logic [2:0] L_OFF = 3'b000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       day_night;
    logic [2:0] mode;
    logic [6:0] idx;
    logic       step;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk;
    logic       err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    light_decoder #(
        .GREEN_T(GREEN_T), .SHORT_T(SHORT_T), .YEL_T(YEL_T), .CLR_T(CLR_T), .FLASH_T(FLASH_T)
    ) dut (
        .clk(clk), .rst_n(rst_n), .day_night(day_night), .mode(mode), .idx(idx),
        .step(step), .main_light(main_light), .side_light(side_light), .walk(walk), .err(err)
    );

    typedef struct {
        logic       dn;
        logic [2:0] md;
        logic [6:0] ix;
        logic [2:0] emain;
        logic [2:0] eside;
        logic       ewalk;
        int         edwell;
        logic       eerr;
    } vec_t;

    vec_t vecs[15];

    // Reference tables taken straight from the phase definitions.
    function automatic bit is_run(input logic dn, input logic [2:0] md);
        return dn && (md < 3'd2);
    endfunction

    function automatic logic [2:0] ref_main(input bit run, input int p);
        if (!run) return (p == 0) ? L_YEL : L_OFF;
        if (p == 2 || p == 8) return L_GRN;
        if (p == 3 || p == 9) return L_YEL;
        return L_RED;
    endfunction

    function automatic logic [2:0] ref_side(input bit run, input int p);
        if (!run) return (p == 0) ? L_RED : L_OFF;
        if (p == 5) return L_GRN;
        if (p == 6) return L_YEL;
        return L_RED;
    endfunction

    function automatic int ref_dwell(input bit run, input int p);
        if (!run) return FLASH_T;
        if (p == 2 || p == 5) return GREEN_T;
        if (p == 8) return SHORT_T;
        if (p == 3 || p == 6 || p == 9) return YEL_T;
        return CLR_T;
    endfunction

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rst_main"}, main_light, L_RED);
        chk({tag, "_rst_side"}, side_light, L_RED);
        chk({tag, "_rst_step"}, step, 0);
        chk({tag, "_rst_walk"}, walk, 0);
        chk({tag, "_rst_err"},  err, 0);
    endtask

    // Counts negedges until step appears; returns budget+1 on timeout.
    task automatic wait_step(input int start, input int budget, output int n);
        n = start;
        while (n <= budget) begin
            tick();
            n++;
            if (step) return;
        end
    endtask

    task automatic apply_vec(input vec_t v, input int k);
        int n;
        string tag;
        tag = $sformatf("vec%0d", k);
        do_reset();
        chk_reset_vals(tag);
        day_night = v.dn;
        mode      = v.md;
        idx       = v.ix;
        rst_n     = 1'b1;
        if (v.eerr) begin
            repeat (3) tick();
            chk({tag, "_err"},  err, 1);
            chk({tag, "_main"}, main_light, L_RED);
            chk({tag, "_side"}, side_light, L_RED);
            chk({tag, "_step"}, step, 0);
            chk({tag, "_walk"}, walk, 0);
            idx = 7'd16;
            repeat (25) begin
                tick();
                chk({tag, "_err_hold_step"}, step, 0);
            end
            chk({tag, "_err_hold"}, err, 1);
            chk({tag, "_err_hold_main"}, main_light, L_RED);
        end else begin
            wait_step(0, 400, n);
            chk({tag, "_latency"}, n, v.edwell + 2);
            chk({tag, "_main"}, main_light, v.emain);
            chk({tag, "_side"}, side_light, v.eside);
            chk({tag, "_walk"}, walk, v.ewalk);
            chk({tag, "_err"},  err, 0);
            tick();
            chk({tag, "_pulse"}, step, 0);
        end
    endtask

    task automatic run_random(input int segs);
        int  p, gap, exp_gap, phases, done;
        bit  run;
        for (int s = 0; s < segs; s++) begin
            if ($urandom % 2) begin
                day_night = 1'b1;
                mode      = 3'($urandom % 2);
            end else begin
                day_night = 1'($urandom % 2);
                mode      = 3'($urandom_range(0, 7));
            end
            run = is_run(day_night, mode);
            p   = $urandom % 10;
            do_reset();
            idx     = 7'(p * 8);
            rst_n   = 1'b1;
            gap     = 0;
            exp_gap = ref_dwell(run, p) + 2;
            phases  = $urandom_range(6, 12);
            done    = 0;
            while (done < phases) begin
                tick();
                gap++;
                if (step) begin
                    chk($sformatf("rnd%0d_gap_p%0d", s, p), gap, exp_gap);
                    chk($sformatf("rnd%0d_main_p%0d", s, p), main_light, ref_main(run, p));
                    chk($sformatf("rnd%0d_side_p%0d", s, p), side_light, ref_side(run, p));
                    chk($sformatf("rnd%0d_walk_p%0d", s, p), walk,
                        (run && p == 5 && mode == 3'd1) ? 1 : 0);
                    p       = (p + 1) % 10;
                    idx     = 7'(p * 8);
                    exp_gap = ref_dwell(run, p) + 2;
                    gap     = 0;
                    done++;
                end else if (gap > 300) begin
                    chk($sformatf("rnd%0d_timeout", s), gap, exp_gap);
                    break;
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        day_night = 1'b1;
        mode      = 3'd0;
        idx       = 7'd0;

        vecs[0]  = '{1'b1, 3'd0, 7'd16, L_GRN, L_RED, 1'b0, GREEN_T, 1'b0};
        vecs[1]  = '{1'b1, 3'd1, 7'd40, L_RED, L_GRN, 1'b1, GREEN_T, 1'b0};
        vecs[2]  = '{1'b1, 3'd0, 7'd40, L_RED, L_GRN, 1'b0, GREEN_T, 1'b0};
        vecs[3]  = '{1'b1, 3'd0, 7'd24, L_YEL, L_RED, 1'b0, YEL_T,   1'b0};
        vecs[4]  = '{1'b1, 3'd1, 7'd64, L_GRN, L_RED, 1'b0, SHORT_T, 1'b0};
        vecs[5]  = '{1'b1, 3'd0, 7'd0,  L_RED, L_RED, 1'b0, CLR_T,   1'b0};
        vecs[6]  = '{1'b1, 3'd1, 7'd48, L_RED, L_YEL, 1'b0, YEL_T,   1'b0};
        vecs[7]  = '{1'b1, 3'd0, 7'd20, L_RED, L_RED, 1'b0, 0,       1'b1};
        vecs[8]  = '{1'b0, 3'd0, 7'd0,  L_YEL, L_RED, 1'b0, FLASH_T, 1'b0};
        vecs[9]  = '{1'b0, 3'd1, 7'd8,  L_OFF, L_OFF, 1'b0, FLASH_T, 1'b0};
        vecs[10] = '{1'b1, 3'd2, 7'd0,  L_YEL, L_RED, 1'b0, FLASH_T, 1'b0};
        vecs[11] = '{1'b1, 3'd0, 7'd80, L_RED, L_RED, 1'b0, 0,       1'b1};
        vecs[12] = '{1'b1, 3'd5, 7'd40, L_OFF, L_OFF, 1'b0, FLASH_T, 1'b0};
        vecs[13] = '{1'b1, 3'd1, 7'd72, L_YEL, L_RED, 1'b0, YEL_T,   1'b0};
        vecs[14] = '{1'b0, 3'd3, 7'd40, L_OFF, L_OFF, 1'b0, FLASH_T, 1'b0};

        do_reset();
        chk_reset_vals("init");

        for (int k = 0; k < 15; k++) apply_vec(vecs[k], k);

        // Class change mid-dwell: green phase aborted, next load decodes as flash.
        do_reset();
        day_night = 1'b1; mode = 3'd0; idx = 7'd16;
        rst_n = 1'b1;
        repeat (11) tick();
        day_night = 1'b0;
        tick();
        chk("abort_step", step, 1);
        chk("abort_main_held", main_light, L_GRN);
        idx = 7'd0;
        tick();
        chk("abort_sync_step", step, 0);
        tick();
        chk("abort_flash_main", main_light, L_YEL);
        chk("abort_flash_side", side_light, L_RED);
        wait_step(2, 300, n);
        chk("abort_flash_period", n, FLASH_T + 2);

        // Mode change within RUN does not abort; walk shows from the next load.
        do_reset();
        day_night = 1'b1; mode = 3'd0; idx = 7'd40;
        rst_n = 1'b1;
        repeat (5) tick();
        mode = 3'd1;
        wait_step(5, 300, n);
        chk("modechg_latency", n, GREEN_T + 2);
        chk("modechg_walk_old", walk, 0);
        wait_step(0, 300, n);
        chk("modechg_period", n, GREEN_T + 2);
        chk("modechg_walk_new", walk, 1);

        // Reset mid-dwell, then restart from LOAD.
        do_reset();
        day_night = 1'b1; mode = 3'd0; idx = 7'd16;
        rst_n = 1'b1;
        repeat (8) tick();
        chk("middwell_main", main_light, L_GRN);
        rst_n = 1'b0;
        tick();
        chk_reset_vals("middwell");
        rst_n = 1'b1;
        tick();
        chk("restart_load_main", main_light, L_RED);
        tick();
        chk("restart_dwell_main", main_light, L_GRN);
        wait_step(2, 300, n);
        chk("restart_latency", n, GREEN_T + 2);

        run_random(14);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/light_decoder.md
LIGHT_DECODER -- requirements
Module: light_decoder

Interface
REQ-001 SHALL have parameters: GREEN_T, default 20, main/side green dwell in cycles; SHORT_T, default 10, secondary main-green dwell; YEL_T, default 4, yellow dwell; CLR_T, default 2, all-red clearance dwell; FLASH_T, default 8, flash half-period. All are 1..255.
REQ-002 SHALL have port clk  input  1  the single clock, all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port day_night  input  1  1=day, 0=night.
REQ-005 SHALL have port mode  input  3  operating mode.
REQ-006 SHALL have port idx  input  7  phase index from the index generator, legal values multiples of 8 in 0..72.
REQ-007 SHALL have port step  output  1  one-cycle pulse that enables the index generator to advance idx.
REQ-008 SHALL have port main_light  output  3  {red,yellow,green} for the main road.
REQ-009 SHALL have port side_light  output  3  {red,yellow,green} for the side road.
REQ-010 SHALL have port walk  output  1  pedestrian walk lamp.
REQ-011 SHALL have port err  output  1  sticky illegal-index flag.

Function
REQ-012 SHALL derive class: RUN when day_night=1 and mode in {0,1}; FLASH otherwise (night, mode 2, mode 3..7).
REQ-013 SHALL decode phase = idx[6:3] and treat the index as illegal when idx[2:0]!=0 or phase>9.
REQ-014 SHALL implement the RUN table (phase: main/side/dwell): 0,1: red/red/CLR_T; 2: green/red/GREEN_T; 3: yellow/red/YEL_T; 4: red/red/CLR_T; 5: red/green/GREEN_T; 6: red/yellow/YEL_T; 7: red/red/CLR_T; 8: green/red/SHORT_T; 9: yellow/red/YEL_T.
REQ-015 SHALL assert walk only in RUN, phase 5, mode=1.
REQ-016 SHALL implement the FLASH table: phase 0: main yellow, side red, FLASH_T; phase 1: all off, FLASH_T; any other legal phase: all off, FLASH_T.
REQ-017 SHALL use a state machine IDLE -> LOAD -> DWELL -> SYNC -> LOAD..., with ERR as absorbing.
REQ-018 In LOAD, SHALL sample idx, day_night and mode, register the lamp outputs for the decoded phase, load cnt = dwell-1 and go to DWELL. An illegal idx SHALL go to ERR instead.
REQ-019 In DWELL, SHALL decrement cnt each cycle. When cnt==0, SHALL assert step for exactly that cycle and go to SYNC.
REQ-020 In SYNC, SHALL keep step=0, hold the outputs and go to LOAD; the updated idx is valid at that point.
REQ-021 Each phase SHALL therefore last dwell+2 cycles, and the lamps SHALL change on the clock edge that leaves LOAD.
REQ-022 SHALL abort the dwell if the class sampled in LOAD differs from the current class while in DWELL: assert step that cycle and go to SYNC.
REQ-023 A mode change within the same class SHALL NOT abort; it takes effect at the next LOAD.
REQ-024 In ERR, SHALL drive err=1, both roads red, walk=0 and step=0, until reset.
REQ-025 cnt SHALL be 8 bits and SHALL never wrap, because the load of dwell-1 is at least 0.

Reset
REQ-026 While rst_n=0 at a clock edge, SHALL set: state=IDLE, cnt=0, step=0, main_light=3'b100, side_light=3'b100, walk=0, err=0.
REQ-027 IDLE SHALL go to LOAD on the first cycle after reset deasserts.
REQ-028 Reset asserted mid-dwell or in ERR SHALL take priority over all transitions.

Structure
REQ-029 Package light_pkg SHALL hold the state enum, the lamp encodings (RED/YEL/GRN/OFF), the phase-count constant 10 and the class encoding.
REQ-030 Sub-module phase_rom SHALL be purely combinational: {class, phase, mode} -> {main, side, walk, dwell}. light_decoder SHALL contain the FSM and the counter.

Verification
REQ-031 Reset, then day, mode 0, idx=16 -> main=GRN, side=RED, step pulse after 20 DWELL cycles, period 22.
REQ-032 Day, mode 1, generator model loops 16..72 -> walk=1 only in phase 5; sequence 2..9 repeats.
REQ-033 Night, idx toggling 0/8 -> main alternates YEL/OFF every FLASH_T+2=10 cycles, side RED/OFF.
REQ-034 Day, mode 0, in phase 2 at cnt=10; then day_night=0 -> step asserted the next DWELL cycle, then FLASH decode.
REQ-035 idx=7'd20 or 7'd80 at LOAD -> err=1, both roads RED, step=0, held until rst_n=0.
REQ-036 rst_n=0 mid-dwell -> all outputs at reset values on the next edge; LOAD restarts one cycle after release.
